// File: rtl/yarp_fetch_ctrl.sv
`timescale 1ns/1ps
// yarp_fetch_ctrl
// Instruction-fetch sequencer for the yarp core. Owns the program counter,
// keeps at most one request outstanding on the req/gnt/rvalid instruction
// memory port, hands each fetched word to decode over valid/ready, and
// applies PC redirects while squashing any fetch already in flight.
//
// Ports
//   clk, reset              core clock, async active-high reset
//   imem_req_o/addr_o       request and word-aligned address (addr = pc_q)
//   imem_gnt_i              request accepted; memory samples addr here
//   imem_rvalid_i/rdata_i   response for the granted request
//   instr_valid_o/instr_o/instr_pc_o/instr_ready_i  decode handshake
//   redirect_i/redirect_pc_i  new fetch path (wins over every other event)
//   redirect_misaligned_o   one-cycle pulse when redirect target had [1:0]!=0
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | one cycle with req low after reset
// REQ   | request asserted at pc_q, waiting for gnt
// WAIT  | request granted, waiting for rvalid
// DROP  | granted request belongs to an old path; discard its response
// HOLD  | instruction presented to decode, waiting for ready
module yarp_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        redirect_misaligned_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DROP = 3'd3,
        HOLD = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = {redirect_pc_i[31:2], 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            instr_q      <= 32'h0;
            instr_pc_q   <= 32'h0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        misaligned_d = redirect_i && (redirect_pc_i[1:0] != 2'b00);

        // A redirect replaces the PC in every state; the per-state logic
        // below only decides where the FSM goes.
        if (redirect_i) begin
            pc_d = redirect_tgt;
        end

        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                // A grant coincident with a redirect still leaves a response
                // in flight for the old address, so it must be drained.
                if (imem_gnt_i) begin
                    state_d = redirect_i ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (redirect_i) begin
                    state_d = imem_rvalid_i ? REQ : DROP;
                end else if (imem_rvalid_i) begin
                    instr_d    = imem_rdata_i;
                    instr_pc_d = pc_q;
                    pc_d       = pc_q + 32'd4;
                    state_d    = HOLD;
                end
            end
            DROP: begin
                if (imem_rvalid_i) begin
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (redirect_i || instr_ready_i) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_req_o            = (state_q == REQ);
    assign imem_addr_o           = pc_q;
    assign instr_valid_o         = (state_q == HOLD);
    assign instr_o               = instr_q;
    assign instr_pc_o            = instr_pc_q;
    assign redirect_misaligned_o = misaligned_q;

endmodule

// File: tb/tb_yarp_fetch_ctrl.sv
`timescale 1ns/1ps
module tb_yarp_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        misaligned;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    // memory model state
    int          rv_delay = 0;
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = 32'h0;
    bit          proto_err = 1'b0;

    always #5 clk = ~clk;

    yarp_fetch_ctrl #(.RESET_PC(32'h0000_0100)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .imem_req_o            (imem_req),
        .imem_addr_o           (imem_addr),
        .imem_gnt_i            (imem_gnt),
        .imem_rvalid_i         (imem_rvalid),
        .imem_rdata_i          (imem_rdata),
        .instr_valid_o         (instr_valid),
        .instr_o               (instr),
        .instr_pc_o            (instr_pc),
        .instr_ready_i         (instr_ready),
        .redirect_i            (redirect),
        .redirect_pc_i         (redirect_pc),
        .redirect_misaligned_o (misaligned)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_F00D;
    endfunction

    // Memory: grants immediately, answers rv_delay cycles after the
    // cycle following the grant; only one request tracked at a time.
    always @(negedge clk) begin
        if (reset) begin
            pend        = 1'b0;
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hBAD0_0000;
        end else begin
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hBAD0_0000;
            if (pend && imem_req) proto_err = 1'b1;
            if (pend) begin
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(paddr);
                    pend        = 1'b0;
                end else begin
                    cnt = cnt - 1;
                end
            end else if (imem_req) begin
                imem_gnt = 1'b1;
                pend     = 1'b1;
                paddr    = imem_addr;
                cnt      = rv_delay;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic sb_pop();
        logic [31:0] e;
        chk_b("sb_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_pc", instr_pc, e);
            chk("sb_instr", instr, mem_word(e));
        end
    endtask

    // Any handshake that the next posedge will complete goes through the
    // scoreboard before time advances.
    task automatic tick();
        if (!reset && instr_valid === 1'b1 && instr_ready === 1'b1) sb_pop();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (instr_valid !== 1'b1 && n < 40);
        chk_b(tag, instr_valid, 1'b1);
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (imem_req !== 1'b1 && n < 40);
        chk_b(tag, imem_req, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        logic [31:0] held;

        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b1;
        rv_delay    = 0;
        repeat (2) @(negedge clk);
        #1;
        chk_b("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 32'h100);
        chk_b("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk_b("rst_mis", misaligned, 1'b0);

        // zero-wait streaming
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        exp_q.push_back(32'h10C);
        reset = 1'b0;
        tick();
        chk_b("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, 32'h100);
        wait_valid("v0", n);
        chk("latency", n, 2);
        chk("pc0", instr_pc, 32'h100);
        wait_valid("v1", n);
        chk("gap1", n, 3);
        chk("pc1", instr_pc, 32'h104);
        wait_valid("v2", n);
        chk("gap2", n, 3);
        chk("pc2", instr_pc, 32'h108);

        // backpressure
        tick();
        instr_ready = 1'b0;
        wait_valid("bp_v", n);
        chk("bp_pc", instr_pc, 32'h10C);
        held = instr;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_b("bp_hold_valid", instr_valid, 1'b1);
            chk("bp_hold_pc", instr_pc, 32'h10C);
            chk("bp_hold_instr", instr, held);
            chk_b("bp_hold_noreq", imem_req, 1'b0);
        end
        instr_ready = 1'b1;
        rv_delay    = 3;
        tick();
        chk_b("bp_next_req", imem_req, 1'b1);
        chk("bp_next_addr", imem_addr, 32'h110);

        // redirect while waiting for a slow response
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        rv_delay    = 0;
        exp_q.push_back(32'h200);
        tick();
        redirect = 1'b0;
        chk_b("drop_noreq", imem_req, 1'b0);
        chk("drop_addr", imem_addr, 32'h200);
        chk_b("drop_novalid", instr_valid, 1'b0);
        wait_req("drop_exit");
        chk("drop_exit_addr", imem_addr, 32'h200);
        wait_valid("rw_v", n);
        chk("rw_pc", instr_pc, 32'h200);

        // redirect coincident with grant
        wait_req("gr_req");
        redirect    = 1'b1;
        redirect_pc = 32'h3C;
        exp_q.push_back(32'h3C);
        tick();
        redirect = 1'b0;
        chk_b("gr_drop_noreq", imem_req, 1'b0);
        chk("gr_drop_addr", imem_addr, 32'h3C);
        wait_req("gr_exit");
        chk("gr_exit_addr", imem_addr, 32'h3C);
        wait_valid("gr_v", n);
        chk("gr_pc", instr_pc, 32'h3C);

        // redirect coincident with rvalid: straight back to REQ
        wait_req("co_req");
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        exp_q.push_back(32'h80);
        tick();
        redirect = 1'b0;
        chk_b("co_req_next", imem_req, 1'b1);
        chk("co_addr", imem_addr, 32'h80);
        wait_valid("co_v", n);
        chk("co_pc", instr_pc, 32'h80);

        // misaligned redirect from HOLD kills the held instruction
        tick();
        instr_ready = 1'b0;
        wait_valid("mis_hold", n);
        chk("mis_hold_pc", instr_pc, 32'h84);
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        exp_q.push_back(32'h200);
        tick();
        redirect    = 1'b0;
        instr_ready = 1'b1;
        chk_b("mis_pulse", misaligned, 1'b1);
        chk_b("mis_killed", instr_valid, 1'b0);
        chk_b("mis_req", imem_req, 1'b1);
        chk("mis_addr", imem_addr, 32'h200);
        tick();
        chk_b("mis_pulse_end", misaligned, 1'b0);
        wait_valid("mis_v", n);
        chk("mis_pc", instr_pc, 32'h200);

        // wraparound
        wait_req("wr_req");
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        tick();
        redirect = 1'b0;
        wait_valid("wr_v0", n);
        chk("wr_pc0", instr_pc, 32'hFFFF_FFFC);
        wait_valid("wr_v1", n);
        chk("wr_pc1", instr_pc, 32'h0);

        // asynchronous reset in WAIT
        rv_delay = 3;
        wait_req("ar_req");
        chk("ar_addr", imem_addr, 32'h4);
        tick();
        reset = 1'b1;
        #1;
        chk_b("ar_req0", imem_req, 1'b0);
        chk("ar_addr0", imem_addr, 32'h100);
        chk_b("ar_valid0", instr_valid, 1'b0);
        chk("ar_instr0", instr, 32'h0);
        chk("ar_instr_pc0", instr_pc, 32'h0);
        chk_b("ar_mis0", misaligned, 1'b0);
        tick();
        rv_delay = 0;
        exp_q.push_back(32'h100);
        reset = 1'b0;
        #1;
        chk_b("ar_idle_noreq", imem_req, 1'b0);
        tick();
        chk_b("ar_restart_req", imem_req, 1'b1);
        chk("ar_restart_addr", imem_addr, 32'h100);
        wait_valid("ar_v", n);
        chk("ar_pc", instr_pc, 32'h100);
        tick();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        chk_b("single_outstanding", proto_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
